booth_control: RTL and testbench

//  Sequencing FSM for the radix-2 Booth multiplier. Sits directly upstream of
//  the accumulator register A, register Q (with its Q[-1] bit) and register M,
//  and drives their load/shift/clear strobes plus the adder add/sub select.

---
 rtl/booth_control.sv | 64 ++++++
 tb/tb_booth_control.sv | 171 +++++++++++++++++
 2 files changed

// File: rtl/booth_control.sv
// booth_control: sequencing FSM for a radix-2 Booth multiplier datapath
module booth_control #(
  parameter int N     = 4,
  parameter int CNT_W = 3
) (
  input  logic clk,
  input  logic reset,
  input  logic start,
  input  logic q0,
  input  logic q_1,
  output logic ResetA,
  output logic CargaA,
  output logic DesplazaA,
  output logic CargaQ,
  output logic DesplazaQ,
  output logic CargaM,
  output logic resta,
  output logic busy,
  output logic fin
);
  typedef enum logic [2:0] {IDLE, LOAD, TEST, ADD, SUB, SHIFT, DONE} state_t;
  state_t state, nxt;
  logic [CNT_W-1:0] cnt, cnt_nxt;
  // next state and iteration count; unknown encodings fall back to IDLE
  always_comb begin
    nxt = IDLE;
    cnt_nxt = cnt;
    case (state)
      IDLE: nxt = start ? LOAD : IDLE;
      LOAD: begin
        nxt = TEST;
        cnt_nxt = CNT_W'(N);
      end
      TEST: nxt = (q0 & ~q_1) ? SUB : (~q0 & q_1) ? ADD : SHIFT;
      ADD, SUB: nxt = SHIFT;
      SHIFT: begin
        nxt = (cnt == CNT_W'(1)) ? DONE : TEST;
        cnt_nxt = (cnt != '0) ? cnt - 1'b1 : cnt;
      end
      DONE: nxt = IDLE;
      default: nxt = IDLE;
    endcase
  end
  // state, counter and strobes registered together; strobes decode the next state so they track the state register exactly
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state <= IDLE;
      cnt <= '0;
      {ResetA, CargaA, DesplazaA, CargaQ, DesplazaQ, CargaM, resta, busy, fin} <= '0;
    end else begin
      state <= nxt;
      cnt <= cnt_nxt;
      ResetA <= nxt == LOAD;
      CargaA <= nxt == ADD || nxt == SUB;
      DesplazaA <= nxt == SHIFT;
      CargaQ <= nxt == LOAD;
      DesplazaQ <= nxt == SHIFT;
      CargaM <= nxt == LOAD;
      resta <= nxt == SUB;
      busy <= nxt != IDLE;
      fin <= nxt == DONE;
    end
  end
endmodule

// File: tb/tb_booth_control.sv
// tb_booth_control: directed vectors driving a behavioural Booth datapath from the controller strobes
module tb_booth_control;
  logic clk = 0, reset = 0, start = 0;
  logic q0, q_1;
  logic ResetA, CargaA, DesplazaA, CargaQ, DesplazaQ, CargaM, resta, busy, fin;
  logic [3:0] a_r = 0, q_r = 0, m_r = 0, cur_mult = 0, cur_mcand = 0;
  logic qm1 = 0;
  logic fin_q = 0;
  logic [8:0] outs;
  int checks = 0, passed = 0;
  int n_sh = 0, n_add = 0, viol = 0;

  typedef struct {
    logic [3:0] mult;
    logic [3:0] mcand;
    logic [7:0] prod;
    int fin_edge;
    int k;
  } vec_t;
  vec_t vecs[6];

  booth_control #(.N(4), .CNT_W(3)) dut (
    .clk(clk), .reset(reset), .start(start), .q0(q0), .q_1(q_1),
    .ResetA(ResetA), .CargaA(CargaA), .DesplazaA(DesplazaA), .CargaQ(CargaQ),
    .DesplazaQ(DesplazaQ), .CargaM(CargaM), .resta(resta), .busy(busy), .fin(fin)
  );

  always #5 clk = ~clk;
  assign q0 = q_r[0];
  assign q_1 = qm1;
  assign outs = {ResetA, CargaA, DesplazaA, CargaQ, DesplazaQ, CargaM, resta, busy, fin};

  always @(posedge clk) begin
    if (CargaM) m_r <= cur_mcand;
    if (CargaQ) begin
      q_r <= cur_mult;
      qm1 <= 1'b0;
    end
    if (ResetA) a_r <= 4'd0;
    else if (CargaA) a_r <= resta ? a_r - m_r : a_r + m_r;
    else if (DesplazaA) a_r <= {a_r[3], a_r[3:1]};
    if (DesplazaQ) begin
      q_r <= {a_r[0], q_r[3:1]};
      qm1 <= q_r[0];
    end
  end

  always @(negedge clk) begin
    if (CargaQ) begin
      n_sh = 0;
      n_add = 0;
    end else begin
      if (DesplazaA) n_sh++;
      if (CargaA) n_add++;
    end
    if ((ResetA && CargaA) || (CargaA && DesplazaA) || (fin && fin_q) || (DesplazaA != DesplazaQ)) viol++;
    fin_q = fin;
  end

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act == exp) passed++;
    else $display("FAIL %s: got %0d expected %0d", name, act, exp);
  endtask

  task automatic run(input logic [3:0] mu, input logic [3:0] mc, output int fe, output int bad_busy);
    cur_mult = mu;
    cur_mcand = mc;
    start = 1;
    @(posedge clk);
    #1;
    start = 0;
    fe = -1;
    bad_busy = 0;
    for (int e = 1; e <= 40; e++) begin
      @(posedge clk);
      #1;
      if (!busy) bad_busy++;
      if (fin) begin
        fe = e;
        break;
      end
    end
  endtask

  initial begin
    int fe, bb, bad;
    vecs[0] = '{4'b0000, 4'b0101, 8'h00, 9, 0};
    vecs[1] = '{4'b0110, 4'b0011, 8'h12, 11, 2};
    vecs[2] = '{4'b0101, 4'b1101, 8'hF1, 13, 4};
    vecs[3] = '{4'b1111, 4'b0111, 8'hF9, 10, 1};
    vecs[4] = '{4'b1000, 4'b0011, 8'hE8, 10, 1};
    vecs[5] = '{4'b0111, 4'b0101, 8'h23, 11, 2};
    repeat (2) @(posedge clk);
    #1;
    chk("reset_outs", int'(outs), 0);
    reset = 1;
    repeat (2) @(posedge clk);
    #1;
    chk("idle_outs", int'(outs), 0);
    for (int i = 0; i < 6; i++) begin
      run(vecs[i].mult, vecs[i].mcand, fe, bb);
      chk($sformatf("v%0d_fin_edge", i), fe, vecs[i].fin_edge);
      chk($sformatf("v%0d_product", i), int'({a_r, q_r}), int'(vecs[i].prod));
      chk($sformatf("v%0d_shifts", i), n_sh, 4);
      chk($sformatf("v%0d_addsub", i), n_add, vecs[i].k);
      chk($sformatf("v%0d_busy_low", i), bb, 0);
      @(posedge clk);
      #1;
      chk($sformatf("v%0d_idle_after", i), int'(outs), 0);
    end
    cur_mult = 4'b0101;
    cur_mcand = 4'b1101;
    start = 1;
    @(posedge clk);
    #1;
    start = 0;
    repeat (2) @(posedge clk);
    #1;
    chk("sub_state_strobes", int'({CargaA, resta, busy}), 7);
    reset = 0;
    #1;
    chk("async_reset_outs", int'(outs), 0);
    @(posedge clk);
    #1;
    chk("reset_held_outs", int'(outs), 0);
    reset = 1;
    bad = 0;
    repeat (4) begin
      @(posedge clk);
      #1;
      if (outs != 0) bad++;
    end
    chk("post_reset_quiet", bad, 0);
    run(4'b0101, 4'b1101, fe, bb);
    chk("post_reset_fin_edge", fe, 13);
    chk("post_reset_product", int'({a_r, q_r}), 8'hF1);
    @(posedge clk);
    #1;
    cur_mult = 4'b0000;
    cur_mcand = 4'b0011;
    start = 1;
    @(posedge clk);
    #1;
    start = 0;
    fe = -1;
    for (int e = 1; e <= 20; e++) begin
      @(posedge clk);
      #1;
      start = (e == 3) || (e >= 7);
      if (fin && fe < 0) fe = e;
      if (fe > 0 && e == fe + 1) chk("b2b_idle_gap", int'(busy), 0);
      if (fe > 0 && e == fe + 2) begin
        chk("b2b_load", int'({ResetA, CargaQ, CargaM, busy}), 15);
        break;
      end
    end
    chk("b2b_fin_edge", fe, 9);
    start = 0;
    for (int e = 0; e < 40 && !fin; e++) begin
      @(posedge clk);
      #1;
    end
    chk("b2b_second_fin", int'(fin), 1);
    repeat (3) @(posedge clk);
    #1;
    chk("exclusion_violations", viol, 0);
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end
endmodule
